// File: rtl/sig_extend.sv
// Registered two's-complement sign extension, IN_WIDTH -> OUT_WIDTH bits.
// Define SIG_EXTEND_PIPE2_EN to add a second output register (latency 2).
module sig_extend #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  reg_in,
  output logic [OUT_WIDTH-1:0] reg_out
);

  logic [OUT_WIDTH-1:0] ext_value;
  logic [OUT_WIDTH-1:0] stage1_reg;

  if (IN_WIDTH < 1 || OUT_WIDTH < IN_WIDTH) begin : g_bad_params
    $error("sig_extend: need IN_WIDTH >= 1 and OUT_WIDTH >= IN_WIDTH");
  end

  // A zero-width replication is illegal, so equal widths take the pass-through branch.
  if (OUT_WIDTH > IN_WIDTH) begin : g_extend
    assign ext_value = {{(OUT_WIDTH-IN_WIDTH){reg_in[IN_WIDTH-1]}}, reg_in};
  end else begin : g_pass
    assign ext_value = reg_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_reg <= '0;
    end else begin
      stage1_reg <= ext_value;
    end
  end

`ifdef SIG_EXTEND_PIPE2_EN
  logic [OUT_WIDTH-1:0] stage2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage2_reg <= '0;
    end else begin
      stage2_reg <= stage1_reg;
    end
  end

  assign reg_out = stage2_reg;
`else
  assign reg_out = stage1_reg;
`endif

endmodule

// File: tb/tb_sig_extend.sv
// Directed bench for sig_extend: default 16->32 instance plus 8->16 and 16->16 sweeps.
module tb_sig_extend;

`ifdef SIG_EXTEND_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] reg_in = '0;
  logic [31:0] reg_out;
  logic [7:0]  in8 = '0;
  logic [15:0] out8;
  logic [15:0] in16 = '0;
  logic [15:0] out16;

  int errors = 0;
  int checks = 0;

  sig_extend #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .reg_in(reg_in), .reg_out(reg_out)
  );

  sig_extend #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .reg_in(in8), .reg_out(out8)
  );

  sig_extend #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .reg_in(in16), .reg_out(out16)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drive one value at a falling edge and wait out the pipeline latency.
  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    reg_in = v;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (reg_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: reg_out=%h expected=%h", reg_out, 32'h0);
    end
    reg_in = 16'hFFFF;
    in8 = 8'hFF;
    in16 = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (reg_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: reg_out=%h expected=%h", reg_out, 32'h0);
    end
    checks++;
    if (out8 !== 16'h0 || out16 !== 16'h0) begin
      errors++;
      $display("FAIL reset_sweep: out8=%h out16=%h expected 0000 0000", out8, out16);
    end
    $display("reset: reg_out=%h out8=%h out16=%h", reg_out, out8, out16);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [15:0] vin [8];
    logic [31:0] vexp [8];
    vin[0] = 16'h000F; vexp[0] = 32'h0000000F;
    vin[1] = 16'h0032; vexp[1] = 32'h00000032;
    vin[2] = 16'hFFEC; vexp[2] = 32'hFFFFFFEC;
    vin[3] = 16'hFFFF; vexp[3] = 32'hFFFFFFFF;
    vin[4] = 16'h8000; vexp[4] = 32'hFFFF8000;
    vin[5] = 16'h7FFF; vexp[5] = 32'h00007FFF;
    vin[6] = 16'h0000; vexp[6] = 32'h00000000;
    vin[7] = 16'h0001; vexp[7] = 32'h00000001;
    for (int i = 0; i < 8; i++) begin
      drive(vin[i]);
      checks++;
      if (reg_out !== vexp[i]) begin
        errors++;
        $display("FAIL vector%0d: in=%h reg_out=%h expected=%h", i, vin[i], reg_out, vexp[i]);
      end else begin
        $display("vector%0d: in=%h reg_out=%h", i, vin[i], reg_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    // Consecutive values every cycle; output lags input by LAT edges.
    logic [15:0] vin [4];
    logic [31:0] vexp [4];
    vin[0] = 16'h1234; vexp[0] = 32'h00001234;
    vin[1] = 16'hC000; vexp[1] = 32'hFFFFC000;
    vin[2] = 16'h4001; vexp[2] = 32'h00004001;
    vin[3] = 16'h8001; vexp[3] = 32'hFFFF8001;
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      @(negedge clk);
      if (i < 4) reg_in = vin[i];
      @(posedge clk);
      #1;
      if (i >= LAT - 1) begin
        checks++;
        if (reg_out !== vexp[i-LAT+1]) begin
          errors++;
          $display("FAIL b2b%0d: reg_out=%h expected=%h", i-LAT+1, reg_out, vexp[i-LAT+1]);
        end else begin
          $display("b2b%0d: reg_out=%h", i-LAT+1, reg_out);
        end
      end
    end
  endtask

  task automatic test_hold;
    drive(16'h0001);
    @(negedge clk);
    reg_in = 16'd10;
    #2;
    reg_in = 16'd15;
    #1;
    checks++;
    if (reg_out !== 32'h00000001) begin
      errors++;
      $display("FAIL hold_between_edges: reg_out=%h expected=%h", reg_out, 32'h1);
    end
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (reg_out !== 32'h0000000F) begin
      errors++;
      $display("FAIL hold_after_edge: reg_out=%h expected=%h", reg_out, 32'hF);
    end
    $display("hold: 10 then 15 -> reg_out=%h", reg_out);
  endtask

  task automatic test_async_reset;
    drive(16'hFFEC);
    checks++;
    if (reg_out !== 32'hFFFFFFEC) begin
      errors++;
      $display("FAIL areset_pre: reg_out=%h expected=%h", reg_out, 32'hFFFFFFEC);
    end
    @(negedge clk);
    reg_in = 16'h1111;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (reg_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_immediate: reg_out=%h expected=%h", reg_out, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (reg_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_held: reg_out=%h expected=%h", reg_out, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    reg_in = 16'h8000;
`ifdef SIG_EXTEND_PIPE2_EN
    @(posedge clk);
    #1;
    checks++;
    if (reg_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_first_edge: reg_out=%h expected=%h", reg_out, 32'h0);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (reg_out !== 32'hFFFF8000) begin
      errors++;
      $display("FAIL areset_release: reg_out=%h expected=%h", reg_out, 32'hFFFF8000);
    end
    $display("async reset: release capture reg_out=%h", reg_out);
  endtask

  task automatic test_sweep;
    logic [7:0]  v8 [2];
    logic [15:0] e8 [2];
    logic [15:0] v16 [2];
    v8[0] = 8'h80;  e8[0] = 16'hFF80;
    v8[1] = 8'h7F;  e8[1] = 16'h007F;
    v16[0] = 16'h8000;
    v16[1] = 16'h7FFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in8 = v8[i];
      in16 = v16[i];
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (out8 !== e8[i]) begin
        errors++;
        $display("FAIL sweep8_%0d: out8=%h expected=%h", i, out8, e8[i]);
      end
      checks++;
      if (out16 !== v16[i]) begin
        errors++;
        $display("FAIL sweep16_%0d: out16=%h expected=%h", i, out16, v16[i]);
      end
      $display("sweep%0d: in8=%h out8=%h in16=%h out16=%h", i, v8[i], out8, v16[i], out16);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
